// File: rtl/pw_conv_pkg.sv
// -----------------------------------------------------------------------------
// pw_conv_pkg
// Configuration for the pointwise (1x1) convolution MAC stage.
// Holds the default geometry (activation/weight width, channels per beat,
// beats per group, parallel output lanes, accumulator width) and the widths
// derived from it. Every module of the block takes its sizes from here.
// -----------------------------------------------------------------------------
package pw_conv_pkg;

    localparam int DATA_WIDTH = 8;   // signed activation / weight width
    localparam int IN_CHANNEL = 9;   // channels presented per input beat
    localparam int NUM_PHASE  = 2;   // beats accumulated into one output group
    localparam int OUT_LANE   = 4;   // filters computed in parallel
    localparam int ACC_WIDTH  = 24;  // signed accumulator / output width

    // Full-precision signed product of one activation and one weight.
    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    // Sum of IN_CHANNEL products cannot overflow with this many guard bits.
    localparam int SUM_WIDTH  = PROD_WIDTH + $clog2(IN_CHANNEL);
    // Phase counter width; kept at least one bit so NUM_PHASE = 1 still builds.
    localparam int PH_WIDTH   = (NUM_PHASE > 1) ? $clog2(NUM_PHASE) : 1;

    localparam logic [PH_WIDTH-1:0] PHASE_LAST = PH_WIDTH'(NUM_PHASE - 1);

endpackage : pw_conv_pkg

// File: rtl/pw_dot_lane.sv
// -----------------------------------------------------------------------------
// pw_dot_lane
// One output lane of the pointwise MAC: IN_CHANNEL signed multipliers whose
// products are registered (stage 1), followed by a combinational reduction of
// those registered products into the lane sum S (consumed by stage 2 in the
// top level).
//
// Ports:
//   clk       system clock, rising edge
//   rstn      synchronous active-low reset (clears the product registers)
//   en_i      capture enable; products only load on valid input beats
//   data_i    IN_CHANNEL signed activations, channel c at [c*DW +: DW]
//   weight_i  IN_CHANNEL signed weights of this lane, same packing
//   sum_o     signed sum of the registered products (SUM_WIDTH bits)
// -----------------------------------------------------------------------------
module pw_dot_lane
    import pw_conv_pkg::*;
(
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                en_i,
    input  logic [IN_CHANNEL*DATA_WIDTH-1:0]    data_i,
    input  logic [IN_CHANNEL*DATA_WIDTH-1:0]    weight_i,
    output logic signed [SUM_WIDTH-1:0]         sum_o
);

    logic signed [PROD_WIDTH-1:0] prod_q [IN_CHANNEL];
    logic signed [SUM_WIDTH-1:0]  sum_d;

    for (genvar gi = 0; gi < IN_CHANNEL; gi++) begin : g_mul
        logic signed [DATA_WIDTH-1:0] act_s;
        logic signed [DATA_WIDTH-1:0] wgt_s;

        assign act_s = data_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign wgt_s = weight_i[gi*DATA_WIDTH +: DATA_WIDTH];

        always_ff @(posedge clk) begin
            if (!rstn) begin
                prod_q[gi] <= '0;
            end else if (en_i) begin
                // Both operands sign-extended to the product width first so
                // the multiply is done in full signed precision.
                prod_q[gi] <= PROD_WIDTH'(act_s) * PROD_WIDTH'(wgt_s);
            end
        end
    end

    // Sign-extended reduction of the registered products; written as a chain,
    // the synthesis tool rebalances it into a tree.
    always_comb begin
        sum_d = '0;
        for (int c = 0; c < IN_CHANNEL; c++) begin
            sum_d = sum_d + SUM_WIDTH'(prod_q[c]);
        end
    end

    assign sum_o = sum_d;

endmodule : pw_dot_lane

// File: rtl/pw_conv_accum.sv
// -----------------------------------------------------------------------------
// pw_conv_accum
// Pointwise (1x1) convolution MAC stage. Each input beat carries IN_CHANNEL
// activations and the OUT_LANE x IN_CHANNEL weights for the current phase.
// OUT_LANE dot products are formed per beat and accumulated over NUM_PHASE
// beats; one result vector per group is emitted. Free-running, no
// backpressure.
//
// Pipeline: edge t   - beat sampled, products registered, flags registered
//           edge t+1 - lane sums accumulated (first beat restarts the sum)
//           edge t+2 - last-phase accumulator copied to out_data, out_valid
//
// Ports:
//   clk         system clock, rising edge
//   rstn        synchronous active-low reset
//   in_valid    data_in / weight_in valid this cycle
//   in_first    with in_valid, marks phase 0 of a group
//   data_in     signed activations, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   weight_in   signed weights, lane l channel c at
//               [(l*IN_CHANNEL+c)*DATA_WIDTH +: DATA_WIDTH]
//   out_valid   one-cycle pulse, result vector valid
//   out_data    signed results, lane l at [l*ACC_WIDTH +: ACC_WIDTH];
//               held until the next out_valid
//   err_resync  one-cycle pulse, partial group abandoned by an early in_first
// -----------------------------------------------------------------------------
module pw_conv_accum
    import pw_conv_pkg::*;
(
    input  logic                                        clk,
    input  logic                                        rstn,
    input  logic                                        in_valid,
    input  logic                                        in_first,
    input  logic [IN_CHANNEL*DATA_WIDTH-1:0]            data_in,
    input  logic [OUT_LANE*IN_CHANNEL*DATA_WIDTH-1:0]   weight_in,
    output logic                                        out_valid,
    output logic [OUT_LANE*ACC_WIDTH-1:0]               out_data,
    output logic                                        err_resync
);

    localparam int LANE_BITS = IN_CHANNEL * DATA_WIDTH;

    // Phase tracking for the beat currently on the inputs.
    logic [PH_WIDTH-1:0] phase_cnt_q, phase_cnt_d;
    logic [PH_WIDTH-1:0] beat_phase;
    logic                beat_first, beat_last, resync_d;

    // Stage 1 flags (aligned with the registered products).
    logic valid1_q, first1_q, last1_q, err_resync_q;
    // Stage 2: accumulators plus a "group complete" flag.
    logic signed [SUM_WIDTH-1:0] lane_sum [OUT_LANE];
    logic signed [ACC_WIDTH-1:0] acc_q [OUT_LANE];
    logic signed [ACC_WIDTH-1:0] acc_d [OUT_LANE];
    logic                        done2_q;
    // Output registers.
    logic                          out_valid_q;
    logic [OUT_LANE*ACC_WIDTH-1:0] out_data_q;

    // An asserted in_first always restarts at phase 0; otherwise the beat
    // takes the running counter (which is 0 after reset, so a group may also
    // start without in_first).
    always_comb begin
        beat_phase  = in_first ? '0 : phase_cnt_q;
        beat_first  = (beat_phase == '0);
        beat_last   = (beat_phase == PHASE_LAST);
        resync_d    = in_valid && in_first && (phase_cnt_q != '0);
        phase_cnt_d = phase_cnt_q;
        if (in_valid) begin
            phase_cnt_d = beat_last ? '0 : beat_phase + PH_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            phase_cnt_q  <= '0;
            valid1_q     <= 1'b0;
            first1_q     <= 1'b0;
            last1_q      <= 1'b0;
            err_resync_q <= 1'b0;
        end else begin
            phase_cnt_q  <= phase_cnt_d;
            valid1_q     <= in_valid;
            first1_q     <= in_valid && beat_first;
            last1_q      <= in_valid && beat_last;
            err_resync_q <= resync_d;
        end
    end

    for (genvar gi = 0; gi < OUT_LANE; gi++) begin : g_lane
        pw_dot_lane u_lane (
            .clk      (clk),
            .rstn     (rstn),
            .en_i     (in_valid),
            .data_i   (data_in),
            .weight_i (weight_in[gi*LANE_BITS +: LANE_BITS]),
            .sum_o    (lane_sum[gi])
        );

        // A first beat overwrites rather than adds, so an abandoned or just
        // completed group never leaks into the next one.
        assign acc_d[gi] = first1_q ? ACC_WIDTH'(lane_sum[gi])
                                    : acc_q[gi] + ACC_WIDTH'(lane_sum[gi]);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int l = 0; l < OUT_LANE; l++) begin
                acc_q[l] <= '0;
            end
            done2_q <= 1'b0;
        end else begin
            if (valid1_q) begin
                for (int l = 0; l < OUT_LANE; l++) begin
                    acc_q[l] <= acc_d[l];
                end
            end
            done2_q <= valid1_q && last1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= done2_q;
            if (done2_q) begin
                for (int l = 0; l < OUT_LANE; l++) begin
                    out_data_q[l*ACC_WIDTH +: ACC_WIDTH] <= acc_q[l];
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign err_resync = err_resync_q;

endmodule : pw_conv_accum

// File: tb/tb_pw_conv_accum.sv
// -----------------------------------------------------------------------------
// tb_pw_conv_accum
// Self-checking bench for pw_conv_accum. A behavioural model computes each
// group's dot products with plain integer arithmetic and schedules the
// expected out_valid / out_data / err_resync by cycle; every cycle the DUT
// outputs are compared against that schedule. A table of directed vectors,
// hand-written multi-cycle sequences and a randomized run drive the inputs.
// -----------------------------------------------------------------------------
module tb_pw_conv_accum;
    import pw_conv_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int IC = IN_CHANNEL;
    localparam int NP = NUM_PHASE;
    localparam int OL = OUT_LANE;
    localparam int AW = ACC_WIDTH;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_first = 1'b0;
    logic [IC*DW-1:0]      data_in = '0;
    logic [OL*IC*DW-1:0]   weight_in = '0;
    logic                  out_valid;
    logic [OL*AW-1:0]      out_data;
    logic                  err_resync;

    pw_conv_accum dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_first   (in_first),
        .data_in    (data_in),
        .weight_in  (weight_in),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .err_resync (err_resync)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_vout = 0;
    int n_err  = 0;

    typedef struct {
        int               due;
        logic [OL*AW-1:0] data;
    } exp_t;

    exp_t             exp_q[$];
    int               err_due_q[$];
    logic [OL*AW-1:0] last_out = '0;
    logic [OL*AW-1:0] cap_q[$];

    // Behavioural model state.
    int     m_cnt = 0;
    longint m_acc [OL];
    int     cur_act [IC];
    int     cur_wgt [OL][IC];

    typedef struct {
        int act_mode;   // 0: constant act_val, 1: channel index
        int act_val;
        int wgt_mode;   // 0: constant wgt_val, 1: lane index + 1
        int wgt_val;
        int exp_lane [OL];
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input longint act, input longint expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, expv);
        end
    endtask

    task automatic chk_vec(input string name, input logic [OL*AW-1:0] act,
                           input logic [OL*AW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    function automatic longint lane_val(input logic [OL*AW-1:0] v, input int l);
        logic signed [AW-1:0] s;
        s = v[l*AW +: AW];
        return longint'(s);
    endfunction

    // Called at each negedge: compare outputs with the scheduled expectations.
    task automatic check_outputs();
        bit exp_v;
        bit exp_e;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        exp_e = (err_due_q.size() > 0) && (err_due_q[0] == cyc);
        chk("out_valid", longint'(out_valid), longint'(exp_v));
        chk("err_resync", longint'(err_resync), longint'(exp_e));
        if (exp_v) begin
            last_out = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        if (exp_e) void'(err_due_q.pop_front());
        chk_vec(exp_v ? "out_data" : "out_data_hold", out_data, last_out);
        if (out_valid === 1'b1) begin
            n_vout++;
            cap_q.push_back(out_data);
            $display("[cyc %0d] out lanes %0d %0d %0d %0d", cyc,
                     lane_val(out_data, 0), lane_val(out_data, 1),
                     lane_val(out_data, 2), lane_val(out_data, 3));
        end
        if (err_resync === 1'b1) n_err++;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_first = 1'b0;
        repeat (n) tick();
    endtask

    task automatic set_pattern(input int amode, input int aval,
                               input int wmode, input int wval);
        for (int c = 0; c < IC; c++) cur_act[c] = (amode == 0) ? aval : c;
        for (int l = 0; l < OL; l++)
            for (int c = 0; c < IC; c++)
                cur_wgt[l][c] = (wmode == 0) ? wval : l + 1;
    endtask

    // Drive one valid beat and advance the model by one beat.
    task automatic apply_beat(input bit first);
        int               ph;
        longint           dot;
        logic [OL*AW-1:0] v;
        for (int c = 0; c < IC; c++) data_in[c*DW +: DW] = DW'(cur_act[c]);
        for (int l = 0; l < OL; l++)
            for (int c = 0; c < IC; c++)
                weight_in[(l*IC+c)*DW +: DW] = DW'(cur_wgt[l][c]);
        in_valid = 1'b1;
        in_first = first;

        ph = first ? 0 : m_cnt;
        if (first && m_cnt != 0) err_due_q.push_back(cyc + 1);
        v = '0;
        for (int l = 0; l < OL; l++) begin
            dot = 0;
            for (int c = 0; c < IC; c++) dot += longint'(cur_act[c]) * longint'(cur_wgt[l][c]);
            m_acc[l] = (ph == 0) ? dot : m_acc[l] + dot;
            v[l*AW +: AW] = AW'(m_acc[l]);
        end
        if (ph == NP - 1) exp_q.push_back('{due: cyc + 3, data: v});
        m_cnt = (ph + 1) % NP;

        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
    endtask

    task automatic do_reset(input int n);
        in_valid = 1'b0;
        in_first = 1'b0;
        rstn = 1'b0;
        exp_q.delete();
        err_due_q.delete();
        last_out = '0;
        m_cnt = 0;
        repeat (n) tick();
        rstn = 1'b1;
    endtask

    initial begin
        int base_v;
        int base_e;

        for (int l = 0; l < OL; l++) m_acc[l] = 0;

        vt[0] = '{0,    1, 0,    2, '{36, 36, 36, 36}};
        vt[1] = '{0, -128, 0, -128, '{294912, 294912, 294912, 294912}};
        vt[2] = '{0, -128, 0,  127, '{-292608, -292608, -292608, -292608}};
        vt[3] = '{1,    0, 1,    0, '{72, 144, 216, 288}};
        vt[4] = '{0,  127, 0, -128, '{-292608, -292608, -292608, -292608}};

        // Reset state: outputs all zero while and after reset is applied.
        do_reset(3);
        chk_vec("reset_out_data", out_data, '0);
        chk("reset_out_valid", longint'(out_valid), 0);

        // Table-driven single groups.
        for (int i = 0; i < 5; i++) begin
            cap_q.delete();
            set_pattern(vt[i].act_mode, vt[i].act_val, vt[i].wgt_mode, vt[i].wgt_val);
            apply_beat(1'b1);
            apply_beat(1'b0);
            idle(4);
            chk($sformatf("vec%0d_count", i), cap_q.size(), 1);
            if (cap_q.size() == 1)
                for (int l = 0; l < OL; l++)
                    chk($sformatf("vec%0d_lane%0d", i, l), lane_val(cap_q[0], l),
                        vt[i].exp_lane[l]);
        end

        // Gap inside a group, then the next group back-to-back.
        cap_q.delete();
        set_pattern(0, 1, 0, 3);
        apply_beat(1'b1);
        idle(5);
        apply_beat(1'b0);
        set_pattern(0, 2, 0, 1);
        apply_beat(1'b1);
        apply_beat(1'b0);
        idle(4);
        chk("gap_count", cap_q.size(), 2);
        if (cap_q.size() == 2) begin
            chk("gap_first", lane_val(cap_q[0], 0), 54);
            chk("gap_second", lane_val(cap_q[1], 3), 36);
        end

        // Early in_first abandons the partial group.
        cap_q.delete();
        base_e = n_err;
        set_pattern(0, 5, 0, 1);
        apply_beat(1'b1);
        set_pattern(0, 1, 0, 1);
        apply_beat(1'b1);
        set_pattern(0, 2, 0, 1);
        apply_beat(1'b0);
        idle(4);
        chk("resync_err_count", n_err - base_e, 1);
        chk("resync_out_count", cap_q.size(), 1);
        if (cap_q.size() == 1) chk("resync_value", lane_val(cap_q[0], 2), 27);

        // Reset in the middle of a group discards it.
        cap_q.delete();
        set_pattern(0, 1, 0, 1);
        apply_beat(1'b1);
        do_reset(1);
        chk_vec("midrst_out_data", out_data, '0);
        apply_beat(1'b1);
        apply_beat(1'b0);
        idle(4);
        chk("midrst_count", cap_q.size(), 1);
        if (cap_q.size() == 1) chk("midrst_value", lane_val(cap_q[0], 1), 18);

        // First beat after reset without in_first acts as phase 0.
        cap_q.delete();
        do_reset(1);
        apply_beat(1'b0);
        apply_beat(1'b0);
        idle(4);
        chk("nofirst_count", cap_q.size(), 1);

        // Randomized traffic checked cycle by cycle against the model.
        base_v = n_vout;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) < 7) begin
                for (int c = 0; c < IC; c++) cur_act[c] = int'($urandom_range(0, 255)) - 128;
                for (int l = 0; l < OL; l++)
                    for (int c = 0; c < IC; c++)
                        cur_wgt[l][c] = int'($urandom_range(0, 255)) - 128;
                apply_beat($urandom_range(0, 9) < 2);
            end else begin
                idle(1);
            end
        end
        idle(5);
        chk("random_outputs_seen", (n_vout - base_v) > 0 ? 1 : 0, 1);
        chk("pending_expectations", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pw_conv_accum
